vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 91 +++++++++
 tb/tb_vga_scanout.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing generator that scans a 320x240 3-bit framebuffer with 2x2 pixel replication.
// Ports:
//   clk          50 MHz system clock; the pixel rate is half of this (one tick every second clk)
//   resetn       asynchronous active-low reset
//   fb_addr      framebuffer read address (row-major 320x240)
//   fb_data      framebuffer colour {R,G,B}, valid one clk after fb_addr changes
//   VGA_CLK      25 MHz pixel clock (the internal phase bit)
//   VGA_HS/VS    active-low syncs
//   VGA_BLANK_N  high in the visible region
//   VGA_SYNC_N   constant 1
//   VGA_R/G/B    10-bit channels, each a replicated colour bit
//   vblank       high while v_cnt >= 480 (safe framebuffer write window)
//   frame_start  one-clk pulse on the tick where h_cnt=0, v_cnt=0
// Optional feature: define SCANOUT_BORDER_EN to force white on the outermost framebuffer rows/columns.
module vga_scanout (
  input  logic        clk,
  input  logic        resetn,
  output logic [16:0] fb_addr,
  input  logic [2:0]  fb_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        vblank,
  output logic        frame_start
);
  logic       phase;
  logic [9:0] h_cnt, v_cnt;
  logic       hs_d, vs_d, vis_d;
  logic [2:0] rgb, colour;
  logic [8:0] x_fb, y_fb;
  logic       h_last, v_last, visible;
  logic [16:0] nxt_addr;
  assign x_fb     = h_cnt[9:1];
  assign y_fb     = v_cnt[9:1];
  assign h_last   = h_cnt == 10'd799;
  assign v_last   = v_cnt == 10'd524;
  assign visible  = h_cnt < 10'd640 && v_cnt < 10'd480;
  // y*320 + x as y*256 + y*64 + x
  assign nxt_addr = {y_fb, 8'b0} + {2'b0, y_fb, 6'b0} + {8'b0, x_fb};
`ifdef SCANOUT_BORDER_EN
  logic border_d;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) border_d <= 1'b0;
    else if (phase) border_d <= x_fb == 9'd0 || x_fb == 9'd319 || y_fb == 9'd0 || y_fb == 9'd239;
  assign colour = border_d ? 3'b111 : fb_data;
`else
  assign colour = fb_data;
`endif
  // Stage 1 (tick that issues the address) latches sync/blank; stage 2 (next tick,
  // when fb_data has arrived) drives the pins so everything lines up with the colour.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      phase       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      fb_addr     <= '0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      vis_d       <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      rgb         <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
        if (h_last) v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        if (visible) fb_addr <= nxt_addr;
        hs_d        <= !(h_cnt >= 10'd656 && h_cnt <= 10'd751);
        vs_d        <= !(v_cnt >= 10'd490 && v_cnt <= 10'd491);
        vis_d       <= visible;
        VGA_HS      <= hs_d;
        VGA_VS      <= vs_d;
        VGA_BLANK_N <= vis_d;
        rgb         <= vis_d ? colour : 3'b000;
      end
    end
  assign VGA_CLK     = phase;
  assign VGA_SYNC_N  = 1'b1;
  assign VGA_R       = {10{rgb[2]}};
  assign VGA_G       = {10{rgb[1]}};
  assign VGA_B       = {10{rgb[0]}};
  assign vblank      = v_cnt >= 10'd480;
  assign frame_start = phase && h_cnt == 10'd0 && v_cnt == 10'd0;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout; expectations are queued by clk index and checked by a monitor.
module tb_vga_scanout;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data = 3'b000;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0]  VGA_R, VGA_G, VGA_B;
  logic        vblank, frame_start;

  vga_scanout dut (
    .clk(clk), .resetn(resetn), .fb_addr(fb_addr), .fb_data(fb_data),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // framebuffer model: one-clk read latency, contents = addr[2:0]
  always @(posedge clk) fb_data <= fb_addr[2:0];

  typedef struct { int cyc; int id; int unsigned exp; } item_t;
  item_t sb[$];
  int n = 0, tests = 0, fails = 0, hs_lo = 0, vs_lo = 0, fs_cnt = 0;
  string names [14] = '{"HS", "VS", "BLANK_N", "R", "G", "B", "fb_addr", "frame_start",
                        "vblank", "VGA_CLK", "SYNC_N", "hs_low_clks", "frame_starts", "vs_low_clks"};
  localparam int unsigned FULL = 32'h3FF;
`ifdef SCANOUT_BORDER_EN
  localparam int unsigned BD = FULL;
`else
  localparam int unsigned BD = 0;
`endif

  // n = posedges since reset release
  always @(posedge clk or negedge resetn)
    if (!resetn) n = 0;
    else n = n + 1;

  function automatic int unsigned act(input int id);
    case (id)
      0: return 32'(VGA_HS);
      1: return 32'(VGA_VS);
      2: return 32'(VGA_BLANK_N);
      3: return 32'(VGA_R);
      4: return 32'(VGA_G);
      5: return 32'(VGA_B);
      6: return 32'(fb_addr);
      7: return 32'(frame_start);
      8: return 32'(vblank);
      9: return 32'(VGA_CLK);
      10: return 32'(VGA_SYNC_N);
      11: return 32'(hs_lo);
      12: return 32'(fs_cnt);
      default: return 32'(vs_lo);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      hs_lo = 0; vs_lo = 0; fs_cnt = 0;
    end else begin
      hs_lo += int'(!VGA_HS);
      vs_lo += int'(!VGA_VS);
      fs_cnt += int'(frame_start);
    end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc == n) begin
        tests++;
        if (act(sb[i].id) !== sb[i].exp) begin
          fails++;
          $display("FAIL %s @clk %0d: got %0h, required %0h", names[sb[i].id], n, act(sb[i].id), sb[i].exp);
        end
        sb.delete(i);
      end
  end

  task automatic expect_at(input int c, input int id, input int unsigned v);
    sb.push_back('{c, id, v});
  endtask

  task automatic expect_rgb(input int c, input int unsigned r, input int unsigned g, input int unsigned b);
    expect_at(c, 3, r);
    expect_at(c, 4, g);
    expect_at(c, 5, b);
  endtask

  task automatic push_reset();
    int unsigned rv [11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 11; i++) expect_at(0, i, rv[i]);
  endtask

  task automatic check_empty(input string what);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expectations never reached, required 0", what, sb.size());
    end
  endtask

  initial begin
    push_reset();
    repeat (2) @(negedge clk);
    #1;
    // pixel P=(v*800+h) appears on the pins after clk 2P+4; its address after clk 2P+2
    expect_at(1, 7, 1); expect_at(1, 9, 1);
    expect_at(2, 7, 0); expect_at(2, 9, 0);
    expect_at(3, 7, 0);
    expect_at(8, 2, 1); expect_rgb(8, BD, BD, FULL);
    expect_at(1315, 0, 1); expect_at(1316, 0, 0);
    expect_at(1507, 0, 0); expect_at(1508, 0, 1);
    expect_at(1604, 11, 192); expect_at(3204, 11, 384);
    expect_at(2876, 6, 318); expect_at(2882, 6, 319);
    expect_at(3000, 6, 319); expect_at(3202, 6, 320);
    expect_at(4822, 6, 325);
    expect_at(2884, 2, 0); expect_rgb(2884, 0, 0, 0);
    expect_at(3204, 2, 1); expect_rgb(3204, BD, BD, BD);
    expect_rgb(3208, 0, 0, FULL);
    expect_rgb(3212, 0, FULL, 0);
    expect_rgb(3220, FULL, 0, 0);
    expect_rgb(3232, FULL, FULL, FULL);
    expect_rgb(3236, 0, 0, 0);
    expect_at(30000, 12, 1); expect_at(30000, 13, 0);
    expect_at(30000, 8, 0); expect_at(30000, 1, 1); expect_at(30000, 10, 1);
    expect_at(32598, 6, 3349);
    resetn = 1'b1;
    repeat (32600) @(posedge clk);
    #2;
    // mid-frame reset at h=300, v=20: everything must clear before the next edge
    check_empty("first_run");
    push_reset();
    resetn = 1'b0;
    @(negedge clk);
    #1;
    expect_at(1, 7, 1); expect_at(1, 9, 1);
    expect_at(6, 6, 1);
    expect_rgb(8, BD, BD, FULL);
    expect_at(1315, 0, 1); expect_at(1316, 0, 0);
    expect_at(3202, 6, 320);
    expect_rgb(3208, 0, 0, FULL);
    resetn = 1'b1;
    repeat (3300) @(posedge clk);
    #1;
    check_empty("restart_run");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
